rr_arbiter16: RTL and testbench
===============================

Name: rr_arbiter16

Overview:
- Round-robin arbiter sharing one resource among 16 requesters.
- Emits both a one-hot grant vector and its 4-bit binary index.
- The binary index is the one-hot-to-binary encoding of the grant, registered here so downstream logic gets a glitch-free, clocked index.
- Sits in front of any shared bus or functional unit whose user is selected by a 4-bit index.

Parameters:
N_REQ, 16, number of requesters (fixed at 16; index width depends on it)
IDX_W, 4, width of binary grant index (log2 N_REQ)
HOLD_MAX, 64, max cycles a grant may be held (used only with ARB_TIMEOUT_EN)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
enable  input  1  allows new grants when high; existing grant is unaffected
req  input  16  request vector, bit i = requester i wants the resource
done  input  1  single-cycle pulse from current owner: transaction finished
grant  output  16  registered one-hot grant; all-zero when no owner
grant_idx  output  4  registered binary index of grant; 0 when no owner
grant_valid  output  1  high while any grant bit is set
timeout  output  1  one-cycle pulse when a grant is revoked by watchdog (tied 0 without option)

Behaviour:
- Reset: clk and rst_n only; asynchronous active-low reset.
  - Asserting rst_n=0 immediately forces grant=0, grant_idx=0, grant_valid=0, timeout=0, ptr=0 and state=IDLE, regardless of clk.
  - Deassertion is sampled synchronously.
- State machine:
  - States IDLE, BUSY, RELEASE; 2-bit encoding; reset state IDLE.
  - ptr is a 4-bit round-robin pointer holding the highest-priority requester for the next arbitration.
- IDLE:
  - If enable=1 and req!=0, pick the first set req bit scanning ptr, ptr+1, ..., 15, 0, ..., ptr-1 (mod 16).
  - Next edge: set grant to that one-hot bit, grant_idx to its index, grant_valid=1; go to BUSY.
  - Latency: req sampled at edge t, grant visible after edge t+1.
  - If enable=0 or req==0, stay in IDLE with outputs 0.
- BUSY:
  - Hold grant/grant_idx constant.
  - Exit when done=1, or when req[grant_idx]=0 (owner withdrew).
  - On exit, next edge: grant=0, grant_idx=0, grant_valid=0, ptr=(grant_idx+1) mod 16 (15 wraps to 0); go to RELEASE.
  - done and req drop in the same cycle count as one release.
  - enable=0 during BUSY has no effect.
  - done while in IDLE or RELEASE is ignored.
- RELEASE:
  - One mandatory bubble cycle, outputs 0; then IDLE unconditionally.
  - Guarantees at least one idle cycle between owners; minimum grant-to-grant spacing is 3 cycles.
- Fairness:
  - A requester holding req high is granted within 16 arbitrations.
  - The last winner has lowest priority in the next arbitration.
- Invariants:
  - grant is always zero or exactly one-hot.
  - grant_idx always equals the binary encoding of grant.
  - grant_valid == |grant.
- Reset mid-BUSY: grant is dropped immediately, ptr returns to 0, and no done is required afterwards.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- When defined:
  - A counter (width clog2(HOLD_MAX)+1) clears on entry to BUSY and increments each BUSY cycle.
  - When it reaches HOLD_MAX-1 with no release, the next edge behaves as a release (ptr advances, go to RELEASE) and timeout pulses high for exactly that one cycle.
  - A normal done on the same cycle as expiry takes precedence: timeout stays 0.
- When undefined: no counter is synthesized, timeout is tied 0, and a grant is held indefinitely until done or req drop.

Test Plan:
1. Reset/idle: rst_n=0 mid-cycle with req=16'hFFFF -> grant, grant_idx and grant_valid are 0 immediately; after release with enable=0 the outputs stay 0 for 10 cycles.
2. Single requester: ptr=0, req=16'h0100 -> one cycle later grant=16'h0100, grant_idx=8; done pulse -> grant=0 next cycle, one RELEASE cycle, ptr=9.
3. Round-robin rotation: req=16'hFFFF held, done pulsed every BUSY cycle -> grant_idx sequence 0,1,2,...,15,0 with 3-cycle spacing; no index is skipped or repeated.
4. Wrap and priority: ptr=14, req=16'h8003 -> grant_idx=15; after release (ptr=0), req=16'h8003 -> grant_idx=0, then 1, then 15.
5. Owner withdraw and enable: owner 5 drops req[5] without done -> release and ptr=6; with enable=0, req=16'h0040 -> no grant until enable=1, then grant_idx=6.
6. With ARB_TIMEOUT_EN, HOLD_MAX=4: grant idx 3, no done -> timeout=1 for one cycle and grant dropped 4 cycles after grant_valid rose; repeat with done on the expiry cycle -> timeout stays 0.

Source files
------------

// File: rtl/rr_arbiter16_if.sv
// Request/grant bundle for the 16-way round-robin arbiter.
// master = requester side, slave = arbiter side.
interface rr_arbiter16_if #(
   parameter int unsigned N_REQ = 16,
   parameter int unsigned IDX_W = 4
);
   logic             enable;
   logic [N_REQ-1:0] req;
   logic             done;
   logic [N_REQ-1:0] grant;
   logic [IDX_W-1:0] grant_idx;
   logic             grant_valid;
   logic             timeout;

   modport master (
      output enable, req, done,
      input  grant, grant_idx, grant_valid, timeout
   );

   modport slave (
      input  enable, req, done,
      output grant, grant_idx, grant_valid, timeout
   );
endinterface

// File: rtl/rr_arbiter16.sv
// 16-way round-robin arbiter with registered one-hot grant and binary index.
// Optional hold watchdog enabled by defining ARB_TIMEOUT_EN.
module rr_arbiter16 #(
   parameter int unsigned N_REQ    = 16,
   parameter int unsigned IDX_W    = 4,
   parameter int unsigned HOLD_MAX = 64
) (
   input logic           clk,
   input logic           rst_n,
   rr_arbiter16_if.slave bus
);

   if (N_REQ != 16 || IDX_W != $clog2(N_REQ)) begin : gen_bad_size
      $error("rr_arbiter16: N_REQ must be 16 and IDX_W must be log2(N_REQ)");
   end
   if (HOLD_MAX < 2) begin : gen_bad_hold
      $error("rr_arbiter16: HOLD_MAX must be at least 2");
   end

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StBusy    = 2'd1,
      StRelease = 2'd2
   } state_t;

   state_t           state_q;
   logic [IDX_W-1:0] ptr_q;
   logic [N_REQ-1:0] grant_q;
   logic [IDX_W-1:0] idx_q;
   logic             valid_q;

   logic [IDX_W-1:0] scan_idx;
   logic [IDX_W-1:0] pick_idx;
   logic             pick_hit;
   logic             busy_exit;

   // Scan from the far end back towards ptr so the nearest set bit wins.
   always_comb begin
      scan_idx = '0;
      pick_idx = '0;
      pick_hit = 1'b0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         scan_idx = ptr_q + IDX_W'(k);
         if (bus.req[scan_idx]) begin
            pick_idx = scan_idx;
            pick_hit = 1'b1;
         end
      end
   end

   // A done together with a withdrawn request is still a single release.
   assign busy_exit = bus.done || !bus.req[idx_q];

`ifdef ARB_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(HOLD_MAX) + 1;

   logic [CntW-1:0] hold_cnt_q;
   logic            timeout_q;
   logic            expire;

   // A normal release on the expiry cycle wins over the watchdog.
   assign expire      = (hold_cnt_q == CntW'(HOLD_MAX - 1)) && !busy_exit;
   assign bus.timeout = timeout_q;
`else
   assign bus.timeout = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         ptr_q      <= '0;
         grant_q    <= '0;
         idx_q      <= '0;
         valid_q    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
         hold_cnt_q <= '0;
         timeout_q  <= 1'b0;
`endif
      end else begin
`ifdef ARB_TIMEOUT_EN
         timeout_q <= 1'b0;
`endif
         unique case (state_q)
            StIdle: begin
               if (bus.enable && pick_hit) begin
                  grant_q    <= N_REQ'(1) << pick_idx;
                  idx_q      <= pick_idx;
                  valid_q    <= 1'b1;
                  state_q    <= StBusy;
`ifdef ARB_TIMEOUT_EN
                  hold_cnt_q <= '0;
`endif
               end
            end
            StBusy: begin
`ifdef ARB_TIMEOUT_EN
               if (busy_exit || expire) begin
                  timeout_q <= expire;
`else
               if (busy_exit) begin
`endif
                  grant_q <= '0;
                  idx_q   <= '0;
                  valid_q <= 1'b0;
                  ptr_q   <= idx_q + 1'b1;
                  state_q <= StRelease;
               end
`ifdef ARB_TIMEOUT_EN
               else begin
                  hold_cnt_q <= hold_cnt_q + 1'b1;
               end
`endif
            end
            StRelease: state_q <= StIdle;
            default:   state_q <= StIdle;
         endcase
      end
   end

   assign bus.grant       = grant_q;
   assign bus.grant_idx   = idx_q;
   assign bus.grant_valid = valid_q;

endmodule

// File: tb/tb_rr_arbiter16.sv
// Self-checking bench for rr_arbiter16: directed scenarios plus random traffic
// compared each cycle against an owner/pointer reference model.
module tb_rr_arbiter16;

`ifdef ARB_TIMEOUT_EN
   localparam int unsigned Hold = 4;
   localparam bit          ToEn = 1'b1;
`else
   localparam int unsigned Hold = 64;
   localparam bit          ToEn = 1'b0;
`endif

   typedef struct packed {
      logic              en;
      logic [15:0]       req;
      logic              done;
      logic signed [7:0] want;  // >=0 granted index, -2 no owner, -1 model only
   } step_t;

   logic clk = 1'b0;
   logic rst_n;
   int   n_vec = 0;
   int   n_err = 0;

   rr_arbiter16_if bus ();

   rr_arbiter16 #(
      .N_REQ   (16),
      .IDX_W   (4),
      .HOLD_MAX(Hold)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   // Reference model: current owner (-1 = none), next-priority pointer,
   // bubble cycles left before arbitration resumes, cycles held so far.
   int m_owner, m_ptr, m_gap, m_held;
   bit m_to;

   function automatic int first_from(logic [15:0] r, int p);
      for (int k = 0; k < 16; k++) begin
         if (r[(p + k) % 16]) return (p + k) % 16;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_owner = -1;
      m_ptr   = 0;
      m_gap   = 0;
      m_held  = 0;
      m_to    = 1'b0;
   endtask

   task automatic model_step(input bit en, input logic [15:0] r, input bit d);
      m_to = 1'b0;
      if (m_owner >= 0) begin
         if (d || !r[m_owner]) begin
            m_ptr   = (m_owner + 1) % 16;
            m_owner = -1;
            m_gap   = 1;
         end else if (ToEn && m_held == int'(Hold) - 1) begin
            m_ptr   = (m_owner + 1) % 16;
            m_owner = -1;
            m_gap   = 1;
            m_to    = 1'b1;
         end else begin
            m_held++;
         end
      end else if (m_gap > 0) begin
         m_gap--;
      end else if (en && r != 16'h0) begin
         m_owner = first_from(r, m_ptr);
         m_held  = 0;
      end
   endtask

   function automatic logic [21:0] exp_vec();
      logic [15:0] g = '0;
      logic [3:0]  i = '0;
      if (m_owner >= 0) begin
         g[m_owner] = 1'b1;
         i          = 4'(m_owner);
      end
      return {g, i, (m_owner >= 0), m_to};
   endfunction

   function automatic logic [21:0] obs();
      return {bus.grant, bus.grant_idx, bus.grant_valid, bus.timeout};
   endfunction

   // Called at a falling edge; drives inputs, lets one rising edge pass,
   // advances the model, and returns at the next falling edge.
   task automatic tick(input bit en, input logic [15:0] r, input bit d);
      bus.enable = en;
      bus.req    = r;
      bus.done   = d;
      @(posedge clk);
      model_step(en, r, d);
      @(negedge clk);
   endtask

   task automatic do_reset();
      bus.enable = 1'b0;
      bus.req    = '0;
      bus.done   = 1'b0;
      rst_n      = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      bus.enable = 1'b0;
      bus.req    = 16'hFFFF;
      bus.done   = 1'b0;
      rst_n      = 1'b0;
      #1;
      n_vec++;
      if (obs() !== 22'h0) begin
         n_err++;
         $display("FAIL reset_initial: got %h want %h", obs(), 22'h0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      tick(1'b1, 16'hFFFF, 1'b0);
      tick(1'b1, 16'hFFFF, 1'b0);
      n_vec++;
      if (obs() !== exp_vec()) begin
         n_err++;
         $display("FAIL reset_pregrant: got %h want %h", obs(), exp_vec());
      end
      #2 rst_n = 1'b0;
      #1;
      n_vec++;
      if (obs() !== 22'h0) begin
         n_err++;
         $display("FAIL reset_async: got %h want %h", obs(), 22'h0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      for (int c = 0; c < 10; c++) begin
         tick(1'b0, 16'hFFFF, 1'b0);
         n_vec++;
         if (obs() !== exp_vec() || bus.grant_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle[%0d]: got %h want %h", c, obs(), exp_vec());
         end
      end
   endtask

   task automatic test_single();
      step_t seq[6];
      seq = '{'{1'b1, 16'h0100, 1'b0, 8'sd8},
              '{1'b1, 16'h0100, 1'b1, -8'sd2},
              '{1'b1, 16'h0000, 1'b0, -8'sd2},
              '{1'b1, 16'hFFFF, 1'b0, 8'sd9},
              '{1'b1, 16'hFFFF, 1'b1, -8'sd2},
              '{1'b1, 16'h0000, 1'b0, -8'sd2}};
      do_reset();
      foreach (seq[i]) begin
         tick(seq[i].en, seq[i].req, seq[i].done);
         n_vec++;
         if (obs() !== exp_vec()) begin
            n_err++;
            $display("FAIL single[%0d]: got %h want %h", i, obs(), exp_vec());
         end
         if (seq[i].want >= 0) begin
            n_vec++;
            if (bus.grant_valid !== 1'b1 || bus.grant_idx !== 4'(seq[i].want)) begin
               n_err++;
               $display("FAIL single_idx[%0d]: got %0d want %0d", i, bus.grant_idx, seq[i].want);
            end
         end else if (seq[i].want == -2) begin
            n_vec++;
            if (bus.grant_valid !== 1'b0 || bus.grant !== 16'h0) begin
               n_err++;
               $display("FAIL single_idle[%0d]: got %h want 0", i, bus.grant);
            end
         end
      end
   endtask

   task automatic test_rotation();
      int   grants = 0;
      int   last   = 0;
      int   cyc    = 0;
      logic pv     = 1'b0;
      do_reset();
      while (grants < 17 && cyc < 300) begin
         tick(1'b1, 16'hFFFF, m_owner >= 0);
         cyc++;
         n_vec++;
         if (obs() !== exp_vec()) begin
            n_err++;
            $display("FAIL rotation_cyc%0d: got %h want %h", cyc, obs(), exp_vec());
         end
         if (bus.grant_valid === 1'b1 && pv !== 1'b1) begin
            n_vec++;
            if (bus.grant_idx !== 4'(grants % 16) || (grants > 0 && cyc - last != 3)) begin
               n_err++;
               $display("FAIL rotation_seq%0d: got idx %0d gap %0d want idx %0d gap 3",
                        grants, bus.grant_idx, cyc - last, grants % 16);
            end
            last = cyc;
            grants++;
         end
         pv = bus.grant_valid;
      end
      n_vec++;
      if (grants != 17) begin
         n_err++;
         $display("FAIL rotation_budget: got %0d grants want 17", grants);
      end
   endtask

   task automatic test_wrap();
      step_t seq[15];
      seq = '{'{1'b1, 16'h2000, 1'b0, 8'sd13},
              '{1'b1, 16'h2000, 1'b1, -8'sd2},
              '{1'b1, 16'h0000, 1'b0, -8'sd2},
              '{1'b1, 16'h8003, 1'b0, 8'sd15},
              '{1'b1, 16'h8003, 1'b1, -8'sd2},
              '{1'b1, 16'h8003, 1'b0, -8'sd2},
              '{1'b1, 16'h8003, 1'b0, 8'sd0},
              '{1'b1, 16'h8003, 1'b1, -8'sd2},
              '{1'b1, 16'h8003, 1'b0, -8'sd2},
              '{1'b1, 16'h8003, 1'b0, 8'sd1},
              '{1'b1, 16'h8003, 1'b1, -8'sd2},
              '{1'b1, 16'h8003, 1'b0, -8'sd2},
              '{1'b1, 16'h8003, 1'b0, 8'sd15},
              '{1'b1, 16'h8003, 1'b1, -8'sd2},
              '{1'b1, 16'h0000, 1'b0, -8'sd2}};
      do_reset();
      foreach (seq[i]) begin
         tick(seq[i].en, seq[i].req, seq[i].done);
         n_vec++;
         if (obs() !== exp_vec()) begin
            n_err++;
            $display("FAIL wrap[%0d]: got %h want %h", i, obs(), exp_vec());
         end
         if (seq[i].want >= 0) begin
            n_vec++;
            if (bus.grant_valid !== 1'b1 || bus.grant_idx !== 4'(seq[i].want)) begin
               n_err++;
               $display("FAIL wrap_idx[%0d]: got %0d want %0d", i, bus.grant_idx, seq[i].want);
            end
         end else if (seq[i].want == -2) begin
            n_vec++;
            if (bus.grant_valid !== 1'b0 || bus.grant !== 16'h0) begin
               n_err++;
               $display("FAIL wrap_idle[%0d]: got %h want 0", i, bus.grant);
            end
         end
      end
   endtask

   task automatic test_withdraw();
      step_t seq[16];
      seq = '{'{1'b1, 16'h0020, 1'b0, 8'sd5},
              '{1'b1, 16'h0020, 1'b0, 8'sd5},
              '{1'b1, 16'h0000, 1'b0, -8'sd2},
              '{1'b0, 16'h0040, 1'b0, -8'sd2},
              '{1'b0, 16'h0040, 1'b0, -8'sd2},
              '{1'b0, 16'h0040, 1'b0, -8'sd2},
              '{1'b0, 16'h0040, 1'b0, -8'sd2},
              '{1'b1, 16'h0040, 1'b0, 8'sd6},
              '{1'b0, 16'h0040, 1'b0, 8'sd6},
              '{1'b1, 16'h0040, 1'b1, -8'sd2},
              '{1'b1, 16'h0000, 1'b1, -8'sd2},
              '{1'b1, 16'h0000, 1'b1, -8'sd2},
              '{1'b1, 16'h0080, 1'b1, 8'sd7},
              '{1'b1, 16'h0080, 1'b0, 8'sd7},
              '{1'b1, 16'h0080, 1'b1, -8'sd2},
              '{1'b1, 16'h0000, 1'b0, -8'sd2}};
      do_reset();
      foreach (seq[i]) begin
         tick(seq[i].en, seq[i].req, seq[i].done);
         n_vec++;
         if (obs() !== exp_vec()) begin
            n_err++;
            $display("FAIL withdraw[%0d]: got %h want %h", i, obs(), exp_vec());
         end
         if (seq[i].want >= 0) begin
            n_vec++;
            if (bus.grant_valid !== 1'b1 || bus.grant_idx !== 4'(seq[i].want)) begin
               n_err++;
               $display("FAIL withdraw_idx[%0d]: got %0d want %0d", i, bus.grant_idx,
                        seq[i].want);
            end
         end else if (seq[i].want == -2) begin
            n_vec++;
            if (bus.grant_valid !== 1'b0 || bus.grant !== 16'h0) begin
               n_err++;
               $display("FAIL withdraw_idle[%0d]: got %h want 0", i, bus.grant);
            end
         end
      end
   endtask

   task automatic test_timeout();
      do_reset();
      tick(1'b1, 16'h0008, 1'b0);
      n_vec++;
      if (obs() !== exp_vec() || bus.grant_idx !== 4'd3) begin
         n_err++;
         $display("FAIL timeout_grant: got %h want %h", obs(), exp_vec());
      end
      for (int t = 1; t <= 5; t++) begin
         tick(1'b1, 16'h0008, 1'b0);
         n_vec++;
         if (obs() !== exp_vec()) begin
            n_err++;
            $display("FAIL timeout_hold[%0d]: got %h want %h", t, obs(), exp_vec());
         end
`ifdef ARB_TIMEOUT_EN
         n_vec++;
         if (bus.grant_valid !== (t < 4) || bus.timeout !== (t == 4)) begin
            n_err++;
            $display("FAIL timeout_expiry[%0d]: got valid %b to %b want valid %b to %b", t,
                     bus.grant_valid, bus.timeout, (t < 4), (t == 4));
         end
`endif
      end
      // Second hold: done lands exactly on the expiry cycle.
      do_reset();
      tick(1'b1, 16'h0008, 1'b0);
      for (int t = 1; t <= 5; t++) begin
         tick(1'b1, 16'h0008, t == 4);
         n_vec++;
         if (obs() !== exp_vec()) begin
            n_err++;
            $display("FAIL timeout_done[%0d]: got %h want %h", t, obs(), exp_vec());
         end
         if (t >= 4) begin
            n_vec++;
            if (bus.timeout !== 1'b0 || bus.grant_valid !== 1'b0) begin
               n_err++;
               $display("FAIL timeout_prec[%0d]: got to %b valid %b want 0 0", t,
                        bus.timeout, bus.grant_valid);
            end
         end
      end
   endtask

   task automatic test_random();
      logic [15:0] r;
      bit          en;
      bit          d;
      do_reset();
      for (int c = 0; c < 600; c++) begin
         en = ($urandom_range(0, 3) != 0);
         r  = 16'($urandom) & 16'($urandom);
         if (m_owner >= 0 && $urandom_range(0, 3) != 0) r[m_owner] = 1'b1;
         d = ($urandom_range(0, 4) == 0);
         tick(en, r, d);
         n_vec++;
         if (obs() !== exp_vec()) begin
            n_err++;
            $display("FAIL random_cyc%0d: got %h want %h", c, obs(), exp_vec());
         end
         n_vec++;
         if ($countones(bus.grant) > 1 || bus.grant_valid !== (bus.grant != 16'h0) ||
             (bus.grant_valid === 1'b1 && bus.grant !== (16'h1 << bus.grant_idx)) ||
             (bus.grant_valid === 1'b0 && bus.grant_idx !== 4'd0)) begin
            n_err++;
            $display("FAIL random_invariant%0d: got grant %h idx %0d valid %b", c, bus.grant,
                     bus.grant_idx, bus.grant_valid);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      test_reset();
      test_single();
      test_rotation();
      test_wrap();
      test_withdraw();
      test_timeout();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
